// File: rtl/bit_serial_pkg.sv
// Purpose: shared state encoding and frame constants for the bit-serial frame controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bit_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Idle cycles after the last product bit so the multiplier pipeline drains.
    localparam int FLUSH_CYCLES = 2;

endpackage

// File: rtl/bit_serial_shift_reg.sv
// Purpose: parallel-load shift register shifting right, with serial shift-in or MSB sign hold.
// Latency: load and shift take effect on the next rising edge; o_ser_out is bit 0.
// Backpressure: none; the owner decides when to load or shift.
module bit_serial_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_dat,
    input  logic         i_shift,
    input  logic         i_sign_hold,
    input  logic         i_ser_in,
    output logic         o_ser_out,
    output logic [W-1:0] o_par
);

    logic [W-1:0] r_dat;
    logic         w_top;

    // Sign hold replicates the MSB so an operand keeps streaming its sign bit.
    assign w_top = i_sign_hold ? r_dat[W-1] : i_ser_in;

    // Load has priority over shift; the register clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dat <= '0;
        end else if (i_load) begin
            r_dat <= i_load_dat;
        end else if (i_shift) begin
            r_dat <= {w_top, r_dat[W-1:1]};
        end
    end

    assign o_ser_out = r_dat[0];
    assign o_par     = r_dat;

endmodule

// File: rtl/bit_serial_frame_ctrl.sv
// Purpose: serialises a signed operand pair LSB first to a bit-serial multiplier and collects its product.
// Latency: K+P_LAT shift cycles + FLUSH_CYCLES, then the product is held in DONE (optional self-check: BIT_SERIAL_SELF_CHECK_EN).
// Backpressure: in_ready only in IDLE; the product is held stable until out_valid && out_ready.
module bit_serial_frame_ctrl
    import bit_serial_pkg::*;
#(
    parameter int N     = 4,
    parameter int P_LAT = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           x,
    output logic           y,
    output logic           first_bit,
    output logic           last_bit,
    input  logic           p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           err
);

    localparam int K         = 2 * N;
    localparam int SHIFT_CYC = K + P_LAT;
    localparam int CW        = $clog2(SHIFT_CYC + 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;

    logic          w_accept;
    logic          w_shift_last;
    logic          w_flush_last;
    logic          w_ser_phase;
    logic          w_samp;
    logic          w_a_ser;
    logic          w_b_ser;
    logic [N-1:0]  w_unused_a_par;
    logic [N-1:0]  w_unused_b_par;
    logic          w_unused_p_ser;
    logic [K-1:0]  w_prod;

    assign w_accept     = (r_state == S_IDLE) && in_valid;
    assign w_shift_last = (r_cnt == CW'(SHIFT_CYC - 1));
    assign w_flush_last = (r_cnt == CW'(FLUSH_CYCLES - 1));
    // Operand bits are only meaningful for the first K cycles of SHIFT.
    assign w_ser_phase  = (r_state == S_SHIFT) && (int'(r_cnt) < K);
    // Product bit i arrives P_LAT cycles after operand bit i.
    assign w_samp       = (r_state == S_SHIFT) && (int'(r_cnt) >= P_LAT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode for the frame sequence.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid)              w_next = S_SHIFT;
            S_SHIFT: if (w_shift_last)          w_next = S_FLUSH;
            S_FLUSH: if (w_flush_last)          w_next = S_DONE;
            S_DONE:  if (out_ready)             w_next = S_IDLE;
            default:                            w_next = S_IDLE;
        endcase
    end

    // Output decode; x/y are forced low outside the serial phase.
    always_comb begin
        in_ready  = 1'b0;
        last_bit  = 1'b1;
        out_valid = 1'b0;
        first_bit = 1'b0;
        x         = 1'b0;
        y         = 1'b0;
        unique case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_SHIFT: begin
                last_bit  = 1'b0;
                first_bit = (r_cnt == '0);
                x         = w_ser_phase & w_a_ser;
                y         = w_ser_phase & w_b_ser;
            end
            S_FLUSH: last_bit  = 1'b0;
            S_DONE:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Cycle counter within SHIFT/FLUSH; restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state != w_next) begin
            r_cnt <= '0;
        end else if ((r_state == S_SHIFT) || (r_state == S_FLUSH)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operands are captured at accept, so later a/b changes cannot disturb the frame.
    bit_serial_shift_reg #(.W(N)) u_sr_a (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_dat (a),
        .i_shift    (w_ser_phase),
        .i_sign_hold(1'b1),
        .i_ser_in   (1'b0),
        .o_ser_out  (w_a_ser),
        .o_par      (w_unused_a_par)
    );

    bit_serial_shift_reg #(.W(N)) u_sr_b (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_dat (b),
        .i_shift    (w_ser_phase),
        .i_sign_hold(1'b1),
        .i_ser_in   (1'b0),
        .o_ser_out  (w_b_ser),
        .o_par      (w_unused_b_par)
    );

    // Product bits enter at the MSB; after K samples bit 0 holds the first one.
    bit_serial_shift_reg #(.W(K)) u_sr_p (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_dat ('0),
        .i_shift    (w_samp),
        .i_sign_hold(1'b0),
        .i_ser_in   (p),
        .o_ser_out  (w_unused_p_ser),
        .o_par      (w_prod)
    );

    assign product = w_prod;

`ifdef BIT_SERIAL_SELF_CHECK_EN
    logic [K-1:0]        r_expect;
    logic                r_err;
    logic signed [K-1:0] w_mul;

    assign w_mul = K'($signed(a)) * K'($signed(b));

    // Reference product captured at accept; mismatch latched on the edge entering DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expect <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_expect <= w_mul;
            end
            if ((r_state == S_FLUSH) && w_flush_last && (w_prod != r_expect)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_frame_ctrl.sv
// Purpose: self-checking bench for bit_serial_frame_ctrl with a behavioural serial multiplier on p.
// Latency: checks frame length, DONE timing and product against signed a*b.
// Backpressure: exercises out_ready stalls and in_valid outside IDLE.
module tb_bit_serial_frame_ctrl;

    localparam int N     = 4;
    localparam int P_LAT = 0;
    localparam int K     = 2 * N;
    localparam int FLUSH = 2;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [N-1:0] a         = '0;
    logic [N-1:0] b         = '0;
    logic         x;
    logic         y;
    logic         first_bit;
    logic         last_bit;
    logic         p         = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [K-1:0] product;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0] exp_a    = '0;
    logic [N-1:0] exp_b    = '0;
    bit           force_p0 = 1'b0;
    logic         exp_err  = 1'b0;

    always #5 clk = ~clk;

    bit_serial_frame_ctrl #(.N(N), .P_LAT(P_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .x        (x),
        .y        (y),
        .first_bit(first_bit),
        .last_bit (last_bit),
        .p        (p),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Bit idx of the operand value sign-extended to 32 bits.
    function automatic logic sext_bit(input logic [N-1:0] v, input int idx);
        int sv;
        sv = $signed(v);
        return sv[idx];
    endfunction

    function automatic logic [K-1:0] model_prod(input logic [N-1:0] va, input logic [N-1:0] vb);
        int sa;
        int sb;
        int pr;
        sa = $signed(va);
        sb = $signed(vb);
        pr = sa * sb;
        return pr[K-1:0];
    endfunction

    // Serial multiplier model and serial-stream checker, evaluated mid-cycle.
    int           mj        = 0;
    bit           prev_last = 1'b1;
    logic [K-1:0] xs        = '0;
    logic [K-1:0] ys        = '0;

    always @(negedge clk) begin
        int          i;
        logic [31:0] mask;
        logic [31:0] pr;
        if (reset) begin
            prev_last = 1'b1;
            mj        = 0;
            p         = 1'b0;
        end else begin
            if (!last_bit) begin
                if (prev_last) begin
                    check("first_bit_set", first_bit, 1);
                    mj = 0;
                    xs = '0;
                    ys = '0;
                end else begin
                    mj++;
                    check("first_bit_clr", first_bit, 0);
                end
                if (mj < K) begin
                    check("x_bit", x, sext_bit(exp_a, mj));
                    check("y_bit", y, sext_bit(exp_b, mj));
                    xs[mj] = x;
                    ys[mj] = y;
                end else begin
                    check("x_zero", x, 0);
                    check("y_zero", y, 0);
                end
                i = mj - P_LAT;
                if (i >= 0 && i < K) begin
                    // Bit i of a product depends only on bits 0..i of the operands.
                    mask = (32'd1 << (i + 1)) - 32'd1;
                    pr   = (32'(xs) & mask) * (32'(ys) & mask);
                    p    = force_p0 ? 1'b0 : pr[i];
                end else begin
                    p = 1'($urandom);
                end
            end else begin
                if (!prev_last) check("frame_len", mj + 1, K + P_LAT + FLUSH);
                p = 1'($urandom);
            end
            prev_last = last_bit;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_x"},        x,         0);
        check({tag, "_y"},        y,         0);
        check({tag, "_first"},    first_bit, 0);
        check({tag, "_last"},     last_bit,  1);
        check({tag, "_in_ready"}, in_ready,  1);
        check({tag, "_out_vld"},  out_valid, 0);
        check({tag, "_product"},  product,   0);
        check({tag, "_err"},      err,       0);
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again.
    task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tbv, input int hold);
        int           t;
        logic [K-1:0] ep;
        logic [K-1:0] held;
        check("in_ready_idle", in_ready, 1);
        a        = ta;
        b        = tbv;
        exp_a    = ta;
        exp_b    = tbv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
        ep       = force_p0 ? '0 : model_prod(ta, tbv);
        t        = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < K + P_LAT + 10);
        check("done_latency", t, K + P_LAT + FLUSH + 1);
        check("product", product, ep);
        check("err", err, exp_err);
        check("in_ready_done", in_ready, 0);
        held = product;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a        = N'($urandom);
            b        = N'($urandom);
            @(negedge clk);
            check("hold_product", product, held);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_last_bit", last_bit, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_after_done", {out_valid, in_ready, last_bit}, 3'b011);
    endtask

    initial begin
        #1;
        check_reset_state("reset");
        @(negedge clk);
        #1;
        reset = 1'b0;

        send(4'd5, 4'd7, 0);
        send(4'd3, 4'hE, 1);
        send(4'h8, 4'h8, 0);

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                send(N'(ia), N'(ib), int'($urandom_range(0, 2)));
            end
        end

        send(N'($urandom), N'($urandom), 10);

        // Abort a frame with reset in bit cycle 3.
        check("abort_in_ready", in_ready, 1);
        a        = 4'd6;
        b        = 4'd5;
        exp_a    = a;
        exp_b    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_in_shift", last_bit, 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        #1;
        reset = 1'b0;
        send(4'd6, 4'hB, 0);

        repeat (20) send(N'($urandom), N'($urandom), int'($urandom_range(0, 3)));

`ifdef BIT_SERIAL_SELF_CHECK_EN
        force_p0 = 1'b1;
        exp_err  = 1'b1;
        send(4'd3, 4'd5, 0);
        force_p0 = 1'b0;
        send(4'd2, 4'd2, 0);
        check("err_sticky", err, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
